pwm_controller: RTL and testbench
=================================

# pwm_controller

Converts an N-bit duty value into a single-bit pulse-width-modulated output with a fixed period of 2^N counter steps. Sits directly downstream of the triangle generator and consumes its `out` as `duty`. Its `period_done` pulse is the intended source of the triangle generator's `ena`, so the triangle advances one step per PWM period and yields a breathing/fading output. Duty updates are applied only at period boundaries, so each period is glitch-free.

## Interface

- `N`, default 8: width of `duty`, the step counter and `duty_latched`; period is 2^N steps.
- `PRESCALE`, default 1: clock cycles per counter step; must be ≥ 1.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `ena`  input  1  when low, all state holds and `period_done` is 0.
- `duty`  input  N  requested duty; sampled only at load points.
- `out`  output  1  PWM output.
- `period_done`  output  1  single-cycle pulse on the final step of each period.
- `duty_latched`  output  N  duty currently being applied.

## Operation

- FSM states are `PWM_IDLE` and `PWM_RUN`.
  - Reset enters `PWM_IDLE`.
  - `PWM_IDLE` → `PWM_RUN` on the first cycle with `ena`=1. On that edge, `duty_latched` ← `duty`, `count` ← 0 and `pre` ← 0.
  - `PWM_RUN` has no exit except `rst`.
- Prescaler `pre` runs 0..PRESCALE-1. It advances only in `PWM_RUN` with `ena`=1.
  - `tick` = (state==`PWM_RUN`) & `ena` & (`pre`==PRESCALE-1).
  - On `tick`, `pre` wraps to 0.
- `count` (N bits) increments by 1 on `tick` and wraps from 2^N-1 to 0.
- `period_done` = `tick` & (`count`==2^N-1). It is combinational from registers and `ena` only.
  - On the same edge, `duty_latched` ← `duty`.
- `out` = (state==`PWM_RUN`) & (`count` < `duty_latched`), unsigned compare. It depends on registers only, with no path from `duty`.
- Boundary duties:
  - `duty`=0: `out` constantly 0.
  - `duty`=2^N-1: high for 2^N-1 of 2^N steps. 100% is not reachable by design.
- `duty` changes mid-period are ignored until the next `period_done` edge. The last value present on that edge wins.
- `ena` low mid-step freezes `pre`, `count`, `duty_latched` and `out` at their current values. Resuming continues exactly where it stopped.

## Timing

- Reset values:
  - state=`PWM_IDLE`, `pre`=0, `count`=0, `duty_latched`=0.
  - Therefore `out`=0 and `period_done`=0.
- `rst` has priority over `ena` and takes effect on the next edge from any state. A reset mid-period discards the period.
- Latency from the first `ena` after reset to a valid `out` is 1 cycle. `out` reflects the newly loaded duty from that edge onward.
- Period length: 2^N × PRESCALE enabled cycles.
- A new duty appears on `out` starting at the step where `count`=0, i.e. the cycle after `period_done`.
- `period_done` is high for exactly one `ena`-high cycle per period. With `PRESCALE`=1 and `ena` held high it is periodic every 2^N cycles.

## Structure

- Shared package `pwm_pkg` holds the `typedef enum logic {PWM_IDLE, PWM_RUN} pwm_state_t`.
- The `count` incrementer reuses the existing `adder_n` sub-module (`b`=1, `c_in`=0); its carry is discarded, which provides the wrap.
- The prescaler is an internal counter of width $clog2(PRESCALE)+1. When `PRESCALE`=1, `tick` reduces to state&`ena`.

## Test plan

- N=4, P=1, `duty`=5, `ena`=1 after reset:
  - `out` high for exactly 5 of every 16 cycles, starting the cycle after the first `ena`.
  - `period_done` pulses at `count`=15, every 16 cycles.
- N=4, P=1, `duty`=0, then `duty`=15:
  - With `duty`=0, `out` is never high.
  - After the next period boundary, `out` is high 15 of 16 cycles.
- Mid-period change, `duty` 3 → 10 at `count`=6:
  - Current period still ends with 3 high cycles.
  - Next period has 10 high cycles.
  - `duty_latched`=10 only after `period_done`.
- N=4, P=3, `ena` toggled 1/0 pseudo-randomly:
  - `count` advances only once per 3 `ena`-high cycles.
  - All state holds while `ena`=0.
  - `period_done` occurs after exactly 48 `ena`-high cycles.
- `rst` asserted at `count`=9 with `ena`=1:
  - Next cycle: `PWM_IDLE`, `out`=0, `duty_latched`=0.
  - Following `ena` cycle reloads `duty` and restarts at `count`=0.
- Integration with the triangle generator (N=4, its `ena`=`period_done`):
  - `duty_latched` steps 0,1,…,15,14,…,0 once per period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the PWM controller slice.
package pwm_pkg;

  // Controller runs once enabled; only reset returns it to idle.
  typedef enum logic {PWM_IDLE, PWM_RUN} pwm_state_t;

endpackage

// File: rtl/adder_n.sv
// Plain N-bit ripple adder with carry in/out, reused as the step-counter incrementer.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  // Widen operands by one bit so the carry falls out of the top of the sum.
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/pwm_controller.sv
// PWM controller: N-bit duty, period of 2^N steps, each step PRESCALE clocks long.
// New duty values are taken only at load points so every period is glitch-free.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int N        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] duty,
  output logic         out,
  output logic         period_done,
  output logic [N-1:0] duty_latched
);

  localparam int            PW         = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [N-1:0]  COUNT_LAST = '1;
  localparam logic [N-1:0]  COUNT_ONE  = N'(1);

  pwm_state_t   state;
  logic [PW-1:0] pre;
  logic [N-1:0]  count;
  logic [N-1:0]  count_inc;
  logic          count_carry_unused;
  logic          tick;

  // The carry out is dropped on purpose: losing it is what wraps count to 0.
  adder_n #(.N(N)) u_count_inc (
    .a     (count),
    .b     (COUNT_ONE),
    .c_in  (1'b0),
    .sum   (count_inc),
    .c_out (count_carry_unused)
  );

  // One tick per PRESCALE enabled cycles; with PRESCALE=1 pre stays 0 and tick is state&ena.
  assign tick        = (state == PWM_RUN) && ena && (pre == PRE_LAST);
  assign period_done = tick && (count == COUNT_LAST);
  assign out         = (state == PWM_RUN) && (count < duty_latched);

  // Controller state, prescaler, step counter and the duty register, all frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PWM_IDLE;
      pre          <= '0;
      count        <= '0;
      duty_latched <= '0;
    end else if (ena) begin
      case (state)
        PWM_IDLE: begin
          state        <= PWM_RUN;
          pre          <= '0;
          count        <= '0;
          duty_latched <= duty;
        end
        PWM_RUN: begin
          if (tick) begin
            pre   <= '0;
            count <= count_inc;
            if (count == COUNT_LAST) begin
              duty_latched <= duty;
            end
          end else begin
            pre <= pre + PRE_ONE;
          end
        end
        default: begin
          state <= PWM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_controller.sv
// Bench for pwm_controller: two instances (N=4, PRESCALE=1 and PRESCALE=3) share
// one stimulus stream and are checked every cycle against an arithmetic model.
module tb_pwm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [3:0] duty = 4'd0;

  logic       out1, pd1;
  logic [3:0] lat1;
  logic       out3, pd3;
  logic [3:0] lat3;

  int total = 0;
  int bad   = 0;

  bit check_en = 1'b0;

  logic       s_out1, s_pd1, s_pd3;
  logic [3:0] s_lat1;

  int m_run [2];
  int m_e   [2];
  int m_lat [2];

  pwm_controller #(.N(4), .PRESCALE(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .duty         (duty),
    .out          (out1),
    .period_done  (pd1),
    .duty_latched (lat1)
  );

  pwm_controller #(.N(4), .PRESCALE(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .duty         (duty),
    .out          (out3),
    .period_done  (pd3),
    .duty_latched (lat3)
  );

  always #5 clk = ~clk;

  function automatic int prescale_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Model: m_e counts enabled cycles since the load; step = m_e / P, count = step mod 16.
  function automatic logic exp_out(input int i);
    int p;
    p = prescale_of(i);
    return (m_run[i] != 0) && (((m_e[i] / p) % 16) < m_lat[i]);
  endfunction

  function automatic logic exp_pd(input int i);
    int p;
    p = prescale_of(i);
    return (m_run[i] != 0) && ena && ((m_e[i] % (16 * p)) == (16 * p - 1));
  endfunction

  function automatic void modelEdge();
    int p;
    for (int i = 0; i < 2; i++) begin
      p = prescale_of(i);
      if (rst) begin
        m_run[i] = 0;
        m_e[i]   = 0;
        m_lat[i] = 0;
      end else if (ena) begin
        if (m_run[i] == 0) begin
          m_run[i] = 1;
          m_e[i]   = 0;
          m_lat[i] = int'(duty);
        end else begin
          m_e[i] = m_e[i] + 1;
          if ((m_e[i] % (16 * p)) == 0) m_lat[i] = int'(duty);
        end
      end
    end
  endfunction

  function automatic logic [3:0] tri_val(input int k);
    return 4'((k <= 15) ? k : (30 - k));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle: set inputs after the falling edge, check, then advance the model on the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] d);
    @(negedge clk);
    rst  = r;
    ena  = e;
    duty = d;
    #1;
    if (check_en) begin
      checkOutput("out_p1", {31'b0, out1}, {31'b0, exp_out(0)});
      checkOutput("pd_p1",  {31'b0, pd1},  {31'b0, exp_pd(0)});
      checkOutput("lat_p1", {28'b0, lat1}, 32'(m_lat[0]));
      checkOutput("out_p3", {31'b0, out3}, {31'b0, exp_out(1)});
      checkOutput("pd_p3",  {31'b0, pd3},  {31'b0, exp_pd(1)});
      checkOutput("lat_p3", {28'b0, lat3}, 32'(m_lat[1]));
    end
    s_out1 = out1;
    s_pd1  = pd1;
    s_lat1 = lat1;
    s_pd3  = pd3;
    @(posedge clk);
    modelEdge();
  endtask

  task automatic runPeriod(input logic [3:0] d, output int highs, output int pds);
    highs = 0;
    pds   = 0;
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b0, 1'b1, d);
      if (s_out1) highs++;
      if (s_pd1)  pds++;
    end
  endtask

  initial begin
    int  highs, pds, eh, k;
    bit  seen, pend;
    logic e;
    logic [3:0] exp_lat_f;

    // Reset and reset-state check.
    applyStimulus(1'b1, 1'b1, 4'd5);
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd5);
    checkOutput("reset_out", {31'b0, s_out1}, 32'd0);
    checkOutput("reset_lat", {28'b0, s_lat1}, 32'd0);

    // duty=5: 5 high steps out of 16, one period_done per period.
    applyStimulus(1'b0, 1'b1, 4'd5);
    runPeriod(4'd5, highs, pds);
    checkOutput("a_highs_1", 32'(highs), 32'd5);
    checkOutput("a_pd_1", 32'(pds), 32'd1);
    checkOutput("a_pd_last", {31'b0, s_pd1}, 32'd1);
    runPeriod(4'd5, highs, pds);
    checkOutput("a_highs_2", 32'(highs), 32'd5);
    checkOutput("a_pd_2", 32'(pds), 32'd1);

    // duty=0 then duty=15 boundaries.
    runPeriod(4'd0, highs, pds);
    checkOutput("b_old_duty", 32'(highs), 32'd5);
    runPeriod(4'd0, highs, pds);
    checkOutput("b_zero", 32'(highs), 32'd0);
    runPeriod(4'd15, highs, pds);
    checkOutput("b_zero_again", 32'(highs), 32'd0);
    runPeriod(4'd3, highs, pds);
    checkOutput("b_full", 32'(highs), 32'd15);

    // Mid-period change 3 -> 10 at count 6.
    highs = 0;
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b0, 1'b1, (j < 6) ? 4'd3 : 4'd10);
      if (s_out1) highs++;
      if (j == 15) checkOutput("c_lat_before", {28'b0, s_lat1}, 32'd3);
    end
    checkOutput("c_highs_old", 32'(highs), 32'd3);
    runPeriod(4'd10, highs, pds);
    checkOutput("c_lat_after", {28'b0, s_lat1}, 32'd10);
    checkOutput("c_highs_new", 32'(highs), 32'd10);

    // Reset at count 9, then reload and restart.
    for (int j = 0; j < 9; j++) applyStimulus(1'b0, 1'b1, 4'd10);
    applyStimulus(1'b1, 1'b1, 4'd10);
    applyStimulus(1'b0, 1'b1, 4'd7);
    checkOutput("d_out_rst", {31'b0, s_out1}, 32'd0);
    checkOutput("d_lat_rst", {28'b0, s_lat1}, 32'd0);
    runPeriod(4'd7, highs, pds);
    checkOutput("d_highs", 32'(highs), 32'd7);
    checkOutput("d_pd", 32'(pds), 32'd1);
    checkOutput("d_lat", {28'b0, s_lat1}, 32'd7);

    // PRESCALE=3 with random ena: first period_done after 48 enabled run cycles.
    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    eh   = 0;
    seen = 1'b0;
    for (int it = 0; it < 2000 && !seen; it++) begin
      e = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, e, 4'($urandom_range(0, 15)));
      if (e) eh++;
      if (s_pd3) seen = 1'b1;
    end
    checkOutput("e_pd_seen", {31'b0, seen}, 32'd1);
    checkOutput("e_ena_cycles", 32'(eh), 32'd48);
    for (int it = 0; it < 300; it++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Triangle generator advanced by period_done drives duty.
    applyStimulus(1'b1, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b1, tri_val(0));
    k    = 0;
    pend = 1'b0;
    exp_lat_f = 4'd0;
    for (int it = 0; it < 600 && k < 31; it++) begin
      applyStimulus(1'b0, 1'b1, tri_val(k));
      if (pend) begin
        checkOutput("f_lat_step", {28'b0, s_lat1}, {28'b0, exp_lat_f});
        pend = 1'b0;
      end
      if (s_pd1) begin
        exp_lat_f = tri_val(k);
        pend = 1'b1;
        k++;
      end
    end
    checkOutput("f_periods", 32'(k), 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
